fix_checksum_stream: RTL

FIX_CHECKSUM_STREAM -- requirements
Module: fix_checksum_stream

---
 rtl/fix_pkg.sv | 28 ++
 rtl/fix_dec3_to_bin.sv | 25 ++
 rtl/fix_checksum_stream.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fix_pkg.sv
// Shared constants, state encoding and helpers for the FIX checksum stream checker.
package fix_pkg;

    localparam logic [7:0] SOH        = 8'h01;
    localparam logic [7:0] ASCII_ONE  = 8'h31;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_EQ   = 8'h3D;

    // Trailer "10=ddd<SOH>" is exactly seven bytes long.
    localparam int unsigned HIST_LEN = 7;
    localparam logic [2:0]  CNT_SAT  = 3'd7;

    // Index 0 holds the newest byte, index HIST_LEN-1 the oldest.
    typedef logic [HIST_LEN-1:0][7:0] hist_t;

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        CALC,
        RESULT
    } state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/fix_dec3_to_bin.sv
// Converts three ASCII decimal digits (most significant first) into a binary value.
module fix_dec3_to_bin
    import fix_pkg::*;
(
    input  logic [7:0] d2,
    input  logic [7:0] d1,
    input  logic [7:0] d0,
    output logic [9:0] value,
    output logic       digit_err
);

    logic [9:0] v2;
    logic [9:0] v1;
    logic [9:0] v0;

    always_comb begin
        digit_err = !(is_digit(d2) && is_digit(d1) && is_digit(d0));
        // For '0'..'9' the low nibble is the digit value.
        v2 = {6'd0, d2[3:0]};
        v1 = {6'd0, d1[3:0]};
        v0 = {6'd0, d0[3:0]};
        value = digit_err ? 10'd0 : (v2 * 10'd100) + (v1 * 10'd10) + v0;
    end

endmodule

// File: rtl/fix_checksum_stream.sv
// Streams FIX messages, accumulates the mod-256 byte sum and checks it against the
// "10=ddd<SOH>" trailer, reporting one result per message plus ok/error counters.
module fix_checksum_stream
    import fix_pkg::*;
#(
    parameter int unsigned BYTES    = 1,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned CHECK_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [8*BYTES-1:0] in_data_i,
    input  logic [BYTES-1:0]   in_keep_i,
    input  logic               in_sop_i,
    input  logic               in_eop_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [7:0]         checksum_o,
    output logic [7:0]         rcv_checksum_o,
    output logic               match_o,
    output logic               fmt_err_o,
    output logic [CNT_W-1:0]   ok_cnt_o,
    output logic [CNT_W-1:0]   err_cnt_o
);

    state_e           state_q, state_d;
    logic [7:0]       sum_q;
    logic [2:0]       cnt_q;
    hist_t            hist_q;

    logic [7:0]       chk_q;
    logic [7:0]       rcv_q;
    logic             match_q;
    logic             fmt_q;
    logic             valid_q;
    logic [CNT_W-1:0] ok_q;
    logic [CNT_W-1:0] err_q;

    logic             xfer;
    logic             load;
    logic             abort;
    logic             compute;
    logic             accept;
    logic             ok_inc;
    logic             err_inc;

    logic [7:0]       acc_sum;
    logic [2:0]       acc_cnt;
    hist_t            acc_hist;

    logic [7:0]       hist_sum;
    logic             trailer_ok;
    logic             fmt_c;
    logic [7:0]       chk_c;
    logic [7:0]       rcv_c;
    logic             match_c;
    logic             fmt_out;
    logic [9:0]       dec_val;
    logic             dig_err;

    // Gated by reset so nothing is offered as accepted while the block is held in reset.
    assign in_ready_o = rst && ((state_q == IDLE) || (state_q == BODY));
    assign xfer       = in_valid_i && in_ready_o;

    // Fold this beat's kept lanes, in wire order, into the running message state.
    always_comb begin
        acc_sum  = in_sop_i ? 8'h00 : sum_q;
        acc_cnt  = in_sop_i ? 3'd0 : cnt_q;
        acc_hist = in_sop_i ? '0 : hist_q;
        for (int i = 0; i < BYTES; i++) begin
            if (in_keep_i[i]) begin
                acc_sum  = acc_sum + in_data_i[8*i +: 8];
                if (acc_cnt != CNT_SAT) begin
                    acc_cnt = acc_cnt + 3'd1;
                end
                acc_hist = {acc_hist[HIST_LEN-2:0], in_data_i[8*i +: 8]};
            end
        end
    end

    fix_dec3_to_bin u_dec (
        .d2        (hist_q[3]),
        .d1        (hist_q[2]),
        .d0        (hist_q[1]),
        .value     (dec_val),
        .digit_err (dig_err)
    );

    always_comb begin
        hist_sum = 8'h00;
        for (int i = 0; i < HIST_LEN; i++) begin
            hist_sum = hist_sum + hist_q[i];
        end
        trailer_ok = (cnt_q == CNT_SAT) && (hist_q[6] == ASCII_ONE) &&
                     (hist_q[5] == ASCII_ZERO) && (hist_q[4] == ASCII_EQ) &&
                     (hist_q[0] == SOH);
        fmt_c = !trailer_ok || dig_err || (dec_val > 10'd255);
        if (CHECK_EN != 0) begin
            // Unfilled history slots are zero, so short messages still subtract correctly.
            chk_c   = sum_q - hist_sum;
            rcv_c   = fmt_c ? 8'h00 : dec_val[7:0];
            match_c = !fmt_c && (chk_c == rcv_c);
            fmt_out = fmt_c;
        end else begin
            chk_c   = sum_q;
            rcv_c   = 8'h00;
            match_c = 1'b0;
            fmt_out = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        abort   = 1'b0;
        compute = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer && in_sop_i) begin
                    load    = 1'b1;
                    state_d = in_eop_i ? CALC : BODY;
                end
            end
            BODY: begin
                if (xfer) begin
                    load  = 1'b1;
                    abort = in_sop_i;
                    if (in_eop_i) begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                compute = 1'b1;
                state_d = RESULT;
            end
            RESULT: begin
                if (valid_q && out_ready_i) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ok_inc  = accept && ((CHECK_EN == 0) || match_q);
    assign err_inc = abort || (accept && !ok_inc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sum_q   <= 8'h00;
            cnt_q   <= 3'd0;
            hist_q  <= '0;
            chk_q   <= 8'h00;
            rcv_q   <= 8'h00;
            match_q <= 1'b0;
            fmt_q   <= 1'b0;
            valid_q <= 1'b0;
            ok_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                sum_q  <= acc_sum;
                cnt_q  <= acc_cnt;
                hist_q <= acc_hist;
            end
            if (compute) begin
                chk_q   <= chk_c;
                rcv_q   <= rcv_c;
                match_q <= match_c;
                fmt_q   <= fmt_out;
            end
            // Result registers settle in CALC; valid follows one cycle into RESULT.
            if (accept) begin
                valid_q <= 1'b0;
            end else if (state_q == RESULT) begin
                valid_q <= 1'b1;
            end
            if (ok_inc && (ok_q != '1)) begin
                ok_q <= ok_q + CNT_W'(1);
            end
            if (err_inc && (err_q != '1)) begin
                err_q <= err_q + CNT_W'(1);
            end
        end
    end

    assign out_valid_o    = valid_q;
    assign checksum_o     = chk_q;
    assign rcv_checksum_o = rcv_q;
    assign match_o        = match_q;
    assign fmt_err_o      = fmt_q;
    assign ok_cnt_o       = ok_q;
    assign err_cnt_o      = err_q;

endmodule
